// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI slave.
//   spi_slv_state_t : responder FSM states
//   SPI_DW_DEFAULT  : default word width in bits
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_DESEL = 2'd0,
    IDLE       = 2'd1,
    ACTIVE     = 2'd2
  } spi_slv_state_t;

  localparam int SPI_DW_DEFAULT = 8;

endpackage

// File: rtl/spi_sync.sv
// spi_sync: N-stage flip-flop synchroniser for one asynchronous input.
//   clk   in   system clock
//   rst   in   synchronous active-high reset, loads RST_VAL into every stage
//   d     in   asynchronous input
//   q     out  synchronised output (last stage)
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;

  always_comb sync_d = {sync_q[STAGES-2:0], d};

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 responder, MSB first, fully oversampled in clk.
//   clk, rst            system clock, synchronous active-high reset
//   sclk, mosi, cs_n    asynchronous SPI inputs from the master
//   miso                slave-out data (registered)
//   tx_data/valid/ready one-word TX holding buffer, write on valid&&ready
//   rx_data, rx_valid   last received word and its 1-cycle strobe
//   tx_underrun         pulses when DUMMY_WORD is loaded for lack of data
//   miso_oe             only with SPI_SLAVE_MISO_OE_EN: high while ACTIVE;
//                       miso then carries the shift MSB unconditionally.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                    DATA_WIDTH  = SPI_DW_DEFAULT,
  parameter int                    SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] DUMMY_WORD  = DATA_WIDTH'(8'hFF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n,
  output logic                  miso,
`ifdef SPI_SLAVE_MISO_OE_EN
  output logic                  miso_oe,
`endif
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun
);

  localparam int DW = DATA_WIDTH;
  localparam int CW = (DW > 2) ? $clog2(DW) : 1;
  localparam int SW = $clog2(SYNC_STAGES + 1);

  logic sclk_s, mosi_s, cs_n_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk, .rst, .d(sclk), .q(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk, .rst, .d(mosi), .q(mosi_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csn  (.clk, .rst, .d(cs_n), .q(cs_n_s));

  spi_slv_state_t state_q, state_d;
  logic          sclk_d1_q;
  logic [DW-1:0] tx_shift_q, tx_shift_d;
  logic [DW-1:0] rx_shift_q, rx_shift_d;
  logic [CW-1:0] bit_cnt_q, bit_cnt_d;
  logic          load_pending_q, load_pending_d;
  logic [DW-1:0] buf_q, buf_d;
  logic          buf_full_q, buf_full_d;
  logic [DW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          underrun_q, underrun_d;
  logic          miso_q, miso_d;
  logic [SW-1:0] settle_q, settle_d;
  logic          load;

  // The cs_n synchroniser resets to "deselected"; without waiting for it to
  // flush, WAIT_DESEL would see that reset value and join a live frame.
  logic settled;
  assign settled = (settle_q == SW'(SYNC_STAGES));

  logic sclk_rise, sclk_fall;
  assign sclk_rise =  sclk_s & ~sclk_d1_q;
  assign sclk_fall = ~sclk_s &  sclk_d1_q;

  always_comb begin
    state_d        = state_q;
    tx_shift_d     = tx_shift_q;
    rx_shift_d     = rx_shift_q;
    bit_cnt_d      = bit_cnt_q;
    load_pending_d = load_pending_q;
    buf_d          = buf_q;
    buf_full_d     = buf_full_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    underrun_d     = 1'b0;
    settle_d       = settled ? settle_q : settle_q + SW'(1);
    load           = 1'b0;

    unique case (state_q)
      WAIT_DESEL: if (settled && cs_n_s) state_d = IDLE;
      IDLE: begin
        if (!cs_n_s) begin
          state_d   = ACTIVE;
          load      = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ACTIVE: begin
        if (cs_n_s) begin
          // Deselect mid-word drops the partial word silently.
          state_d        = IDLE;
          bit_cnt_d      = '0;
          load_pending_d = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[DW-2:0], mosi_s};
            if (bit_cnt_q == CW'(DW - 1)) begin
              rx_data_d      = rx_shift_d;
              rx_valid_d     = 1'b1;
              bit_cnt_d      = '0;
              load_pending_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
          // After the last rise the next fall presents the following word's
          // MSB instead of shifting, so words run back to back.
          if (sclk_fall) begin
            if (load_pending_q) begin
              load           = 1'b1;
              load_pending_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q << 1;
            end
          end
        end
      end
      default: state_d = WAIT_DESEL;
    endcase

    if (load) begin
      if (buf_full_q) begin
        tx_shift_d = buf_q;
        buf_full_d = 1'b0;
      end else begin
        tx_shift_d = DUMMY_WORD;
        underrun_d = 1'b1;
      end
    end

    // Write is judged on the pre-load buffer state, so a write racing a load
    // of an empty buffer lands in the buffer while the load takes the dummy.
    if (tx_valid && !buf_full_q) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end

`ifdef SPI_SLAVE_MISO_OE_EN
    miso_d = tx_shift_d[DW-1];
`else
    miso_d = (state_d == ACTIVE) ? tx_shift_d[DW-1] : 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_DESEL;
      sclk_d1_q      <= 1'b0;
      tx_shift_q     <= '0;
      rx_shift_q     <= '0;
      bit_cnt_q      <= '0;
      load_pending_q <= 1'b0;
      buf_q          <= '0;
      buf_full_q     <= 1'b0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      underrun_q     <= 1'b0;
      miso_q         <= 1'b0;
      settle_q       <= '0;
    end else begin
      state_q        <= state_d;
      sclk_d1_q      <= sclk_s;
      tx_shift_q     <= tx_shift_d;
      rx_shift_q     <= rx_shift_d;
      bit_cnt_q      <= bit_cnt_d;
      load_pending_q <= load_pending_d;
      buf_q          <= buf_d;
      buf_full_q     <= buf_full_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      underrun_q     <= underrun_d;
      miso_q         <= miso_d;
      settle_q       <= settle_d;
    end
  end

`ifdef SPI_SLAVE_MISO_OE_EN
  logic miso_oe_q;
  always_ff @(posedge clk) begin
    if (rst) miso_oe_q <= 1'b0;
    else     miso_oe_q <= (state_d == ACTIVE);
  end
  assign miso_oe = miso_oe_q;
`endif

  assign miso        = miso_q;
  assign tx_ready    = ~buf_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;
  import spi_pkg::*;

  localparam int HALF = 5;  // clk cycles per sclk half period

  logic       clk = 1'b0, rst = 1'b1;
  logic       sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
  logic       miso;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid, tx_underrun;
`ifdef SPI_SLAVE_MISO_OE_EN
  logic       miso_oe;
`endif

  spi_slave #(.DATA_WIDTH(8), .SYNC_STAGES(2), .DUMMY_WORD(8'hFF)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .miso(miso),
`ifdef SPI_SLAVE_MISO_OE_EN
    .miso_oe(miso_oe),
`endif
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  int rx_cnt = 0, ur_cnt = 0;
  logic [7:0] last_rx = '0;

  always @(posedge clk) begin
    if (rx_valid) begin rx_cnt++; last_rx = rx_data; end
    if (tx_underrun) ur_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic [7:0] w, output logic [7:0] r);
    logic [7:0] t;
    t = '0;
    for (int i = 7; i >= 0; i--) begin
      mosi = w[i];
      tick(HALF);
      t[i] = miso;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    r = t;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = i[0];
      tick(HALF); sclk = 1'b1;
      tick(HALF); sclk = 1'b0;
    end
  endtask

  task automatic write_tx(input logic [7:0] d);
    int t;
    t = 0;
    tx_data = d; tx_valid = 1'b1;
    while (!tx_ready && t < 50) begin tick(1); t++; end
    check("tx_ready_wait", 32'(t < 50), 32'd1);
    tick(1);
    tx_valid = 1'b0;
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] mo;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;

  initial begin
    vec_t vecs[5];
    logic [7:0] got, got2;
    int rb, ub;

    vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
    vecs[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[4] = '{8'h5A, 8'hC3, 8'h5A, 8'hC3};

    tick(3);
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_underrun", tx_underrun, 0);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("rst_miso_oe", miso_oe, 0);
`endif
    rst = 1'b0;
    tick(8);
    check("idle_state", dut.state_q, IDLE);

    // Single-word frames with a loaded buffer; the final fall reloads from the
    // now-empty buffer, so each frame ends with exactly one underrun.
    foreach (vecs[k]) begin
      write_tx(vecs[k].tx);
      rb = rx_cnt; ub = ur_cnt;
      cs_n = 1'b0;
      xfer(vecs[k].mo, got);
      tick(HALF); cs_n = 1'b1; tick(8);
      check($sformatf("v%0d_miso", k), got, vecs[k].exp_miso);
      check($sformatf("v%0d_rx", k), last_rx, vecs[k].exp_rx);
      check($sformatf("v%0d_rx_cnt", k), rx_cnt - rb, 1);
      check($sformatf("v%0d_ur_cnt", k), ur_cnt - ub, 1);
    end

    // Back-to-back words, second buffer write while word 1 is in flight.
    write_tx(8'h11);
    rb = rx_cnt;
    cs_n = 1'b0;
    fork
      xfer(8'h01, got);
      begin tick(20); write_tx(8'h22); end
    join
    xfer(8'h02, got2);
    tick(HALF); cs_n = 1'b1; tick(8);
    check("b2b_miso0", got, 8'h11);
    check("b2b_miso1", got2, 8'h22);
    check("b2b_rx_cnt", rx_cnt - rb, 2);
    check("b2b_rx", last_rx, 8'h02);

    // Empty buffer at selection.
    ub = ur_cnt;
    cs_n = 1'b0;
    tick(6);
    check("empty_ur_cnt", ur_cnt - ub, 1);
    check("empty_miso_msb", miso, 1);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("oe_active", miso_oe, 1);
`endif
    xfer(8'h00, got);
    tick(HALF); cs_n = 1'b1; tick(8);
    check("empty_miso", got, 8'hFF);
`ifdef SPI_SLAVE_MISO_OE_EN
    check("oe_after_cs", miso_oe, 0);
`endif

    // Abort after 5 rises, then a clean frame must be byte-aligned.
    rb = rx_cnt;
    cs_n = 1'b0;
    pulses(5);
    tick(HALF); cs_n = 1'b1; tick(8);
    check("abort_rx_cnt", rx_cnt - rb, 0);
    check("abort_state", dut.state_q, IDLE);
    cs_n = 1'b0;
    xfer(8'h5A, got);
    tick(HALF); cs_n = 1'b1; tick(8);
    check("realign_rx", last_rx, 8'h5A);
    check("realign_rx_cnt", rx_cnt - rb, 1);

    // Reset in the middle of a frame.
    write_tx(8'h3C);
    cs_n = 1'b0;
    pulses(3);
    rst = 1'b1;
    tick(1);
    check("mrst_miso", miso, 0);
    check("mrst_tx_ready", tx_ready, 1);
    check("mrst_rx_data", rx_data, 0);
    check("mrst_rx_valid", rx_valid, 0);
    check("mrst_underrun", tx_underrun, 0);
    rst = 1'b0;
    rb = rx_cnt;
    pulses(5);
    tick(HALF);
    check("mrst_ignored_rx", rx_cnt - rb, 0);
    check("mrst_state", dut.state_q, WAIT_DESEL);
    check("mrst_miso_hold", miso, 0);
    cs_n = 1'b1; tick(8);
    check("mrst_idle", dut.state_q, IDLE);
    write_tx(8'hA5);
    cs_n = 1'b0;
    xfer(8'h3C, got);
    tick(HALF); cs_n = 1'b1; tick(8);
    check("mrst_miso_word", got, 8'hA5);
    check("mrst_rx", last_rx, 8'h3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
